// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants and types for the bus-slot request initiator
//
// Contents:
//   BUS_ADDR_WIDTH / BUS_DATA_WIDTH : default bus address/data widths
//   state_t                         : request FSM state encoding
//   cmd_t                           : command record at default widths
//   cmd_bits()                      : packed width of a {we, addr, wdata} record

package bus_pkg;

    localparam int BUS_ADDR_WIDTH = 17;
    localparam int BUS_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Record layout, MSB first: {we, addr, wdata}
    typedef struct packed {
        logic                      we;
        logic [BUS_ADDR_WIDTH-1:0] addr;
        logic [BUS_DATA_WIDTH-1:0] wdata;
    } cmd_t;

    function automatic int cmd_bits(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - two-flop synchronizer for a single asynchronous level
//
// Ports:
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, both flops clear to 0
//   d       : asynchronous input
//   q       : synchronized output, two edges of latency

module sync_ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_request.sv
// rtl/bus_request.sv - initiator side of the pending/done bus-slot handshake
//
// Buffers up to two read/write commands and presents them one at a time to the
// slot synchronizer as a held pending request, then returns a response upstream.
// Optional feature macro: BUS_REQUEST_TIMEOUT_EN (abort REQ after TIMEOUT cycles).
//
// Ports:
//   clk, reset_n                          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata : upstream command
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err : upstream response
//   pending/bus_we/bus_addr/bus_wdata     : request to the slot synchronizer
//   bus_rdata/done                        : completion from the slot synchronizer

module bus_request
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  pending,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  done
);

    localparam int CW = cmd_bits(ADDR_WIDTH, DATA_WIDTH);

    state_t state;
    logic   done_s;
    logic   timeout_hit;

    sync_ff u_done_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (done),
        .q       (done_s)
    );

    // ---------------- command FIFO (2 entries) ----------------
    logic [CW-1:0] fifo_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          push;
    logic          pop;
    logic [CW-1:0] head;

    assign cmd_ready = (count != 2'd2);
    assign push      = cmd_valid && cmd_ready;
    // The slot is released from the FIFO as soon as REQ resolves, so a new
    // command can be buffered while the response is still outstanding.
    assign pop       = (state == ST_REQ) && (done_s || timeout_hit);
    assign head      = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_we, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- optional REQ timeout ----------------
`ifdef BUS_REQUEST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] tmo_cnt;
    logic          rsp_err_q;

    assign timeout_hit = (tmo_cnt == TW'(TIMEOUT - 1)) && !done_s;
    assign rsp_err     = rsp_err_q;

    // Held at zero outside REQ, which clears it on every entry to REQ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_REQ) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // done_s takes priority over a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_err_q <= 1'b0;
        end else if (state == ST_REQ) begin
            if (done_s) begin
                rsp_err_q <= 1'b0;
            end else if (timeout_hit) begin
                rsp_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // ---------------- request FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pending   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Never start while the previous done is still visible.
                    if (count != 2'd0 && !done_s) begin
                        bus_we    <= head[CW-1];
                        bus_addr  <= head[CW-2 -: ADDR_WIDTH];
                        bus_wdata <= head[DATA_WIDTH-1:0];
                        pending   <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (done_s) begin
                        rsp_rdata <= bus_we ? '0 : bus_rdata;
                        pending   <= 1'b0;
                        state     <= ST_RELEASE;
                    end else if (timeout_hit) begin
                        rsp_rdata <= '0;
                        pending   <= 1'b0;
                        state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!done_s) begin
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_request.sv
// tb/tb_bus_request.sv - self-checking bench for bus_request

module tb_bus_request;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [16:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        pending;
    logic        bus_we;
    logic [16:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic        done = 1'b0;

    int checks = 0;
    int errors = 0;

    bus_request #(
        .ADDR_WIDTH (17),
        .DATA_WIDTH (8),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .pending   (pending),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd;
        logic [7:0]  exp_rdata;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic we, input logic [16:0] addr, input logic [7:0] wdata);
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_level(input logic lvl, input int is_rsp, input int max, input string name);
        int n = 0;
        while (((is_rsp != 0) ? rsp_valid : pending) !== lvl && n < max) begin
            tick();
            n++;
        end
        if (((is_rsp != 0) ? rsp_valid : pending) !== lvl) begin
            check({name, "_timeout"}, 32'(n), 32'(max + 1));
        end
    endtask

    // Responder plus upstream acceptor for one command; stall = cycles of rsp_ready=0.
    task automatic service(input logic we, input logic [16:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rd, input logic [7:0] exp_rd,
                           input int stall, input string name);
        logic bad;
        wait_level(1'b1, 0, 40, {name, "_pend"});
        check({name, "_we"}, 32'(bus_we), 32'(we));
        check({name, "_addr"}, 32'(bus_addr), 32'(addr));
        check({name, "_wdata"}, 32'(bus_wdata), 32'(wdata));
        tick();
        tick();
        done      = 1'b1;
        bus_rdata = rd;
        wait_level(1'b0, 0, 10, {name, "_fall"});
        tick();
        done      = 1'b0;
        bus_rdata = 8'h5A;
        wait_level(1'b1, 1, 10, {name, "_rsp"});
        check({name, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
        check({name, "_err"}, 32'(rsp_err), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || pending !== 1'b0) bad = 1'b1;
        end
        if (stall > 0) check({name, "_stall_stable"}, 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({name, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        check({name, "_no_pend_after_accept"}, 32'(pending), 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{we: 1'b0, addr: 17'h1E810, wdata: 8'h00, rd: 8'hA5, exp_rdata: 8'hA5};
        vecs[1] = '{we: 1'b1, addr: 17'h08000, wdata: 8'h3C, rd: 8'hEE, exp_rdata: 8'h00};
        vecs[2] = '{we: 1'b0, addr: 17'h1FFFF, wdata: 8'h99, rd: 8'hFF, exp_rdata: 8'hFF};
        vecs[3] = '{we: 1'b1, addr: 17'h00000, wdata: 8'hFF, rd: 8'h11, exp_rdata: 8'h00};

        tick();
        tick();
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset_n = 1'b1;
        tick();

        // Table-driven single transactions with exact edge timing.
        for (int v = 0; v < 4; v++) begin
            logic bad;
            push(vecs[v].we, vecs[v].addr, vecs[v].wdata);
            check($sformatf("v%0d_pend_edge0", v), 32'(pending), 32'd0);
            tick();
            check($sformatf("v%0d_pend_edge1", v), 32'(pending), 32'd1);
            check($sformatf("v%0d_bus_we", v), 32'(bus_we), 32'(vecs[v].we));
            check($sformatf("v%0d_bus_addr", v), 32'(bus_addr), 32'(vecs[v].addr));
            check($sformatf("v%0d_bus_wdata", v), 32'(bus_wdata), 32'(vecs[v].wdata));
            bad = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (bus_we !== vecs[v].we || bus_addr !== vecs[v].addr ||
                    bus_wdata !== vecs[v].wdata || pending !== 1'b1) bad = 1'b1;
            end
            done      = 1'b1;
            bus_rdata = vecs[v].rd;
            tick();
            tick();
            if (bus_we !== vecs[v].we || bus_addr !== vecs[v].addr ||
                bus_wdata !== vecs[v].wdata) bad = 1'b1;
            check($sformatf("v%0d_bus_stable", v), 32'(bad), 32'd0);
            check($sformatf("v%0d_pend_done2", v), 32'(pending), 32'd1);
            tick();
            check($sformatf("v%0d_pend_done3", v), 32'(pending), 32'd0);
            tick();
            tick();
            tick();
            done      = 1'b0;
            bus_rdata = 8'h5A;
            tick();
            tick();
            check($sformatf("v%0d_rsp_early", v), 32'(rsp_valid), 32'd0);
            tick();
            check($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'd1);
            check($sformatf("v%0d_rsp_rdata", v), 32'(rsp_rdata), 32'(vecs[v].exp_rdata));
            check($sformatf("v%0d_rsp_err", v), 32'(rsp_err), 32'd0);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check($sformatf("v%0d_rsp_accept", v), 32'(rsp_valid), 32'd0);
        end

        // FIFO fill with a stalled responder, then in-order completion.
        push(1'b0, 17'h10001, 8'h00);
        push(1'b1, 17'h10002, 8'h77);
        check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        check("fill_pending", 32'(pending), 32'd1);
        tick();
        tick();
        check("fill_cmd_ready_hold", 32'(cmd_ready), 32'd0);
        service(1'b0, 17'h10001, 8'h00, 8'h42, 8'h42, 0, "fifo_a");
        check("fifo_c_ready", 32'(cmd_ready), 32'd1);
        push(1'b0, 17'h10003, 8'h00);
        check("fifo_b_restart", 32'(pending), 32'd1);
        service(1'b1, 17'h10002, 8'h77, 8'h13, 8'h00, 0, "fifo_b");
        service(1'b0, 17'h10003, 8'h00, 8'hC7, 8'hC7, 0, "fifo_c");

        // Response backpressure with a second command queued behind it.
        push(1'b0, 17'h00123, 8'h00);
        push(1'b1, 17'h00456, 8'h81);
        service(1'b0, 17'h00123, 8'h00, 8'h6B, 8'h6B, 10, "bp_a");
        service(1'b1, 17'h00456, 8'h81, 8'h00, 8'h00, 0, "bp_b");

        // Reset while pending, with a second command buffered.
        push(1'b0, 17'h0AAAA, 8'h00);
        push(1'b0, 17'h05555, 8'h00);
        check("rstmid_pending_before", 32'(pending), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_pending_async", 32'(pending), 32'd0);
        tick();
        reset_n = 1'b1;
        check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (pending !== 1'b0 || rsp_valid !== 1'b0) seen = 1'b1;
            end
            check("rstmid_quiet", 32'(seen), 32'd0);
        end
        check("rstmid_cmd_ready_after", 32'(cmd_ready), 32'd1);

`ifdef BUS_REQUEST_TIMEOUT_EN
        // Responder never answers; next queued command proceeds normally.
        push(1'b0, 17'h12345, 8'h00);
        push(1'b0, 17'h12346, 8'h00);
        check("tmo_pend_rise", 32'(pending), 32'd1);
        begin
            int n = 0;
            while (pending === 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check("tmo_cycles", 32'(n), 32'd16);
        end
        tick();
        check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        check("tmo_rsp_err", 32'(rsp_err), 32'd1);
        check("tmo_rsp_rdata", 32'(rsp_rdata), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        service(1'b0, 17'h12346, 8'h00, 8'h3E, 8'h3E, 0, "tmo_next");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
